// File: rtl/uart_lock_sequencer.sv
// PIN-gated door lock sequencer fed by a uart_rx byte stream.
// Optional feature macro: LOCK_AUTO_RELOCK_EN (open timer and auto-relock).
module uart_lock_sequencer #(
    parameter int unsigned PIN_LEN        = 4,
    parameter logic [63:0] PIN            = 64'h31323334,
    parameter int unsigned OPEN_CYCLES    = 250_000_000,
    parameter int unsigned ENTRY_TIMEOUT  = 500_000_000,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1_500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       lock_open,
    output logic       entry_active,
    output logic       lockout,
    output logic [3:0] fail_count
);

    localparam int unsigned IDX_W = $clog2(PIN_LEN) + 1;
    localparam int unsigned ENT_W = $clog2(ENTRY_TIMEOUT) + 1;
    localparam int unsigned LCK_W = $clog2(LOCKOUT_CYCLES) + 1;

    localparam logic [7:0] CH_A = 8'h41;
    localparam logic [7:0] CH_C = 8'h43;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_OPEN,
        S_LOCKOUT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               miss_q, miss_d;
    logic [ENT_W-1:0]   ent_tmr_q, ent_tmr_d;
    logic [LCK_W-1:0]   lck_tmr_q, lck_tmr_d;
    logic [3:0]         fail_q, fail_d;
    logic               lock_open_q, entry_active_q, lockout_q;

    logic               is_digit;
    logic               digit_miss;
    logic               final_miss;
    logic [3:0]         fail_inc;
    logic [63:0]        pin_shifted;
    int unsigned        shamt;

`ifdef LOCK_AUTO_RELOCK_EN
    localparam int unsigned OPN_W = $clog2(OPEN_CYCLES) + 1;
    logic [OPN_W-1:0]   opn_tmr_q, opn_tmr_d;
`else
    logic               unused_open_cfg;
    assign unused_open_cfg = ^OPEN_CYCLES;
`endif

    // Digits are never stored: compare against the PIN digit at the current index.
    always_comb begin
        shamt       = 8 * (PIN_LEN - 1 - 32'(idx_q));
        pin_shifted = PIN >> shamt;
        is_digit    = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
        digit_miss  = (rx_byte != pin_shifted[7:0]);
        final_miss  = miss_q | digit_miss;
        fail_inc    = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        miss_d    = miss_q;
        ent_tmr_d = ent_tmr_q;
        lck_tmr_d = lck_tmr_q;
        fail_d    = fail_q;
`ifdef LOCK_AUTO_RELOCK_EN
        opn_tmr_d = opn_tmr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_byte == CH_A) begin
                    state_d   = S_ENTRY;
                    idx_d     = '0;
                    miss_d    = 1'b0;
                    ent_tmr_d = '0;
                end
            end
            S_ENTRY: begin
                // Timeout wins over a byte arriving in the same cycle.
                if (ent_tmr_q == ENT_W'(ENTRY_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    if (!is_digit) begin
                        state_d = S_IDLE;
                    end else begin
                        ent_tmr_d = '0;
                        miss_d    = final_miss;
                        if (idx_q != '1) idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(PIN_LEN - 1)) begin
                            if (final_miss) begin
                                fail_d = fail_inc;
                                if (fail_inc == 4'(MAX_FAILS)) begin
                                    state_d   = S_LOCKOUT;
                                    lck_tmr_d = '0;
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end else begin
                                state_d = S_OPEN;
                                fail_d  = '0;
`ifdef LOCK_AUTO_RELOCK_EN
                                opn_tmr_d = '0;
`endif
                            end
                        end
                    end
                end else if (ent_tmr_q != '1) begin
                    ent_tmr_d = ent_tmr_q + ENT_W'(1);
                end
            end
            S_OPEN: begin
`ifdef LOCK_AUTO_RELOCK_EN
                if (opn_tmr_q == OPN_W'(OPEN_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    if (rx_valid && rx_byte == CH_C) state_d = S_IDLE;
                    if (opn_tmr_q != '1) opn_tmr_d = opn_tmr_q + OPN_W'(1);
                end
`else
                if (rx_valid && rx_byte == CH_C) state_d = S_IDLE;
`endif
            end
            S_LOCKOUT: begin
                if (lck_tmr_q == LCK_W'(LOCKOUT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end else if (lck_tmr_q != '1) begin
                    lck_tmr_d = lck_tmr_q + LCK_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            miss_q         <= 1'b0;
            ent_tmr_q      <= '0;
            lck_tmr_q      <= '0;
            fail_q         <= '0;
            lock_open_q    <= 1'b0;
            entry_active_q <= 1'b0;
            lockout_q      <= 1'b0;
`ifdef LOCK_AUTO_RELOCK_EN
            opn_tmr_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            miss_q         <= miss_d;
            ent_tmr_q      <= ent_tmr_d;
            lck_tmr_q      <= lck_tmr_d;
            fail_q         <= fail_d;
            lock_open_q    <= (state_d == S_OPEN);
            entry_active_q <= (state_d == S_ENTRY);
            lockout_q      <= (state_d == S_LOCKOUT);
`ifdef LOCK_AUTO_RELOCK_EN
            opn_tmr_q      <= opn_tmr_d;
`endif
        end
    end

    assign lock_open    = lock_open_q;
    assign entry_active = entry_active_q;
    assign lockout      = lockout_q;
    assign fail_count   = fail_q;

endmodule
